// File: rtl/filter_svf_pkg.sv
// filter_svf_pkg: shared constants, mode codes and FSM encoding for the multi-channel SVF
package filter_svf_pkg;
  localparam int F_FRAC = 17;
  localparam int Q1_FRAC = 16;
  localparam int COEF_W = 18;
  localparam logic [COEF_W-1:0] Q1_RESET = 18'h10000;
  typedef enum logic [1:0] {SVF_LOW, SVF_BAND, SVF_HIGH, SVF_NOTCH} svf_mode_e;
  typedef enum logic [2:0] {IDLE, MUL_LOW, MUL_HIGH, MUL_BAND, WRITE} state_e;
endpackage

// File: rtl/filter_svf_mc_if.sv
// filter_svf_mc_if: config, input stream and result bundle of the multi-channel SVF
interface filter_svf_mc_if
  import filter_svf_pkg::*;
#(
  parameter int DATA_BITS = 12,
  parameter int CHANNELS = 4
);
  localparam int CW = $clog2(CHANNELS);
  logic cfg_we;
  logic [CW-1:0] cfg_chan;
  logic [COEF_W-1:0] cfg_f;
  logic [COEF_W-1:0] cfg_q1;
  logic [1:0] cfg_mode;
  logic in_valid;
  logic in_ready;
  logic [CW-1:0] in_chan;
  logic signed [DATA_BITS-1:0] in_sample;
  logic out_valid;
  logic [CW-1:0] out_chan;
  logic signed [DATA_BITS-1:0] out_sample;
  logic signed [DATA_BITS-1:0] out_low;
  logic signed [DATA_BITS-1:0] out_band;
  logic signed [DATA_BITS-1:0] out_high;
  logic signed [DATA_BITS-1:0] out_notch;
  modport master (
    output cfg_we, cfg_chan, cfg_f, cfg_q1, cfg_mode, in_valid, in_chan, in_sample,
    input in_ready, out_valid, out_chan, out_sample, out_low, out_band, out_high, out_notch
  );
  modport slave (
    input cfg_we, cfg_chan, cfg_f, cfg_q1, cfg_mode, in_valid, in_chan, in_sample,
    output in_ready, out_valid, out_chan, out_sample, out_low, out_band, out_high, out_notch
  );
endinterface

// File: rtl/filter_svf_sat.sv
// filter_svf_sat: signed width reduction, clamping when FILTER_SVF_MC_SATURATE_EN is defined, wrapping otherwise
module filter_svf_sat #(
  parameter int IW = 17,
  parameter int OW = 16
) (
  input  logic signed [IW-1:0] d_i,
  output logic signed [OW-1:0] q_o
);
`ifdef FILTER_SVF_MC_SATURATE_EN
  logic [IW-OW:0] hi;
  logic ovf;
  // clamp when the dropped bits are not a pure sign extension
  always_comb begin
    hi = d_i[IW-1:OW-1];
    ovf = !((&hi) || !(|hi));
    q_o = ovf ? (d_i[IW-1] ? {1'b1, {(OW-1){1'b0}}} : {1'b0, {(OW-1){1'b1}}}) : OW'(d_i);
  end
`else
  assign q_o = OW'(d_i);
`endif
endmodule

// File: rtl/filter_svf_mc.sv
// filter_svf_mc: time-multiplexed multi-channel Chamberlin SVF, one shared multiplier (FILTER_SVF_MC_SATURATE_EN selects clamping)
module filter_svf_mc
  import filter_svf_pkg::*;
#(
  parameter int DATA_BITS = 12,
  parameter int CHANNELS = 4,
  parameter int GUARD_BITS = 4
) (
  input logic clk,
  input logic rst_n,
  filter_svf_mc_if.slave bus
);
  localparam int SW = DATA_BITS + GUARD_BITS;
  localparam int SW1 = SW + 1;
  localparam int PW = SW + COEF_W + 1;
  localparam int CW = $clog2(CHANNELS);
  state_e state_q, state_d;
  logic [COEF_W-1:0] f_cfg_q [CHANNELS];
  logic [COEF_W-1:0] q1_cfg_q [CHANNELS];
  logic [1:0] mode_cfg_q [CHANNELS];
  logic signed [SW-1:0] low_st_q [CHANNELS];
  logic signed [SW-1:0] band_st_q [CHANNELS];
  logic [COEF_W-1:0] f_q, q1_q, mul_c;
  logic [1:0] mode_q;
  logic [CW-1:0] chan_q;
  logic signed [SW-1:0] in_q, low_q, band_q, high_q, notch_q, mul_a, acc_r, notch_r;
  logic signed [PW-1:0] prod;
  logic signed [SW1-1:0] term, acc_sum, notch_sum;
  logic signed [DATA_BITS-1:0] o_low, o_band, o_high, o_notch, o_sel;
  logic out_valid_q;
  logic [CW-1:0] out_chan_q;
  logic signed [DATA_BITS-1:0] out_sample_q, out_low_q, out_band_q, out_high_q, out_notch_q;
  logic accept, chan_ok, cfg_ok;

  assign bus.in_ready = rst_n && state_q == IDLE;
  assign bus.out_valid = out_valid_q;
  assign bus.out_chan = out_chan_q;
  assign bus.out_sample = out_sample_q;
  assign bus.out_low = out_low_q;
  assign bus.out_band = out_band_q;
  assign bus.out_high = out_high_q;
  assign bus.out_notch = out_notch_q;

  // handshake decode, shared multiplier operand steering and the per-state sum
  always_comb begin
    accept = bus.in_valid && bus.in_ready;
    chan_ok = 32'(bus.in_chan) < CHANNELS;
    cfg_ok = bus.cfg_we && 32'(bus.cfg_chan) < CHANNELS;
    mul_a = state_q == MUL_BAND ? high_q : band_q;
    mul_c = state_q == MUL_HIGH ? q1_q : f_q;
    prod = PW'(mul_a) * PW'($signed({1'b0, mul_c}));
    term = SW1'(prod >>> (state_q == MUL_HIGH ? Q1_FRAC : F_FRAC));
    acc_sum = state_q == MUL_HIGH ? SW1'(in_q) - SW1'(low_q) - term
            : (state_q == MUL_BAND ? SW1'(band_q) : SW1'(low_q)) + term;
    notch_sum = SW1'(high_q) + SW1'(low_q);
    o_sel = mode_q == SVF_BAND ? o_band : mode_q == SVF_HIGH ? o_high : mode_q == SVF_NOTCH ? o_notch : o_low;
  end

  filter_svf_sat #(.IW(SW1), .OW(SW)) u_sat_acc (.d_i(acc_sum), .q_o(acc_r));
  filter_svf_sat #(.IW(SW1), .OW(SW)) u_sat_notch (.d_i(notch_sum), .q_o(notch_r));
  filter_svf_sat #(.IW(SW), .OW(DATA_BITS)) u_out_low (.d_i(low_q), .q_o(o_low));
  filter_svf_sat #(.IW(SW), .OW(DATA_BITS)) u_out_band (.d_i(band_q), .q_o(o_band));
  filter_svf_sat #(.IW(SW), .OW(DATA_BITS)) u_out_high (.d_i(high_q), .q_o(o_high));
  filter_svf_sat #(.IW(SW), .OW(DATA_BITS)) u_out_notch (.d_i(notch_q), .q_o(o_notch));

  // sequence IDLE -> MUL_LOW -> MUL_HIGH -> MUL_BAND -> WRITE; bad channels are swallowed in IDLE
  always_comb begin
    state_d = state_q;
    state_d = state_q == IDLE ? (accept && chan_ok ? MUL_LOW : IDLE)
            : state_q == MUL_LOW ? MUL_HIGH
            : state_q == MUL_HIGH ? MUL_BAND
            : state_q == MUL_BAND ? WRITE : IDLE;
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else state_q <= state_d;
  end

  // per-channel coefficient registers; an accept in the same cycle still sees the old values
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CHANNELS; i++) begin
        f_cfg_q[i] <= '0;
        q1_cfg_q[i] <= Q1_RESET;
        mode_cfg_q[i] <= SVF_LOW;
      end
    end else if (cfg_ok) begin
      f_cfg_q[bus.cfg_chan] <= bus.cfg_f;
      q1_cfg_q[bus.cfg_chan] <= bus.cfg_q1;
      mode_cfg_q[bus.cfg_chan] <= bus.cfg_mode;
    end
  end

  // working registers, channel state write-back and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CHANNELS; i++) begin
        low_st_q[i] <= '0;
        band_st_q[i] <= '0;
      end
      f_q <= '0;
      q1_q <= '0;
      mode_q <= '0;
      chan_q <= '0;
      in_q <= '0;
      low_q <= '0;
      band_q <= '0;
      high_q <= '0;
      notch_q <= '0;
      out_valid_q <= 1'b0;
      out_chan_q <= '0;
      out_sample_q <= '0;
      out_low_q <= '0;
      out_band_q <= '0;
      out_high_q <= '0;
      out_notch_q <= '0;
    end else begin
      out_valid_q <= state_q == WRITE;
      if (accept && chan_ok) begin
        chan_q <= bus.in_chan;
        in_q <= SW'(bus.in_sample);
        f_q <= f_cfg_q[bus.in_chan];
        q1_q <= q1_cfg_q[bus.in_chan];
        mode_q <= mode_cfg_q[bus.in_chan];
        low_q <= low_st_q[bus.in_chan];
        band_q <= band_st_q[bus.in_chan];
      end
      if (state_q == MUL_LOW) low_q <= acc_r;
      if (state_q == MUL_HIGH) high_q <= acc_r;
      if (state_q == MUL_BAND) begin
        band_q <= acc_r;
        notch_q <= notch_r;
      end
      if (state_q == WRITE) begin
        low_st_q[chan_q] <= low_q;
        band_st_q[chan_q] <= band_q;
        out_chan_q <= chan_q;
        out_sample_q <= o_sel;
        out_low_q <= o_low;
        out_band_q <= o_band;
        out_high_q <= o_high;
        out_notch_q <= o_notch;
      end
    end
  end
endmodule

// File: tb/tb_filter_svf_mc.sv
// tb_filter_svf_mc: directed vector bench for filter_svf_mc (expectations follow FILTER_SVF_MC_SATURATE_EN)
module tb_filter_svf_mc;
  localparam int DB = 12;
  localparam int CH = 3;
  localparam int CW = 2;
`ifdef FILTER_SVF_MC_SATURATE_EN
  localparam int BIG_LOW = 2047;
`else
  localparam int BIG_LOW = -2;
`endif
  typedef struct {
    int ch, s, lo, bd, hi, nt, os;
  } vec_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  vec_t tbl [6];
  int lat, seen, ic, last, outs, exp_ch;
  logic acc;
  int q [$];

  filter_svf_mc_if #(.DATA_BITS(DB), .CHANNELS(CH)) bus ();
  filter_svf_mc #(.DATA_BITS(DB), .CHANNELS(CH), .GUARD_BITS(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_near(input string name, input int act, input int exp, input int tol);
    checks++;
    if (act < exp - tol || act > exp + tol) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d +/- %0d", name, act, exp, tol);
    end
  endtask

  task automatic chk_out(input string tag, input int lo, input int bd, input int hi, input int nt, input int os);
    chk({tag, "_low"}, int'(bus.out_low), lo);
    chk({tag, "_band"}, int'(bus.out_band), bd);
    chk({tag, "_high"}, int'(bus.out_high), hi);
    chk({tag, "_notch"}, int'(bus.out_notch), nt);
    chk({tag, "_sample"}, int'(bus.out_sample), os);
  endtask

  task automatic cfg_write(input int ch, input int f, input int q1, input int m);
    bus.cfg_we = 1'b1;
    bus.cfg_chan = CW'(ch);
    bus.cfg_f = 18'(f);
    bus.cfg_q1 = 18'(q1);
    bus.cfg_mode = 2'(m);
    @(posedge clk); #1;
    bus.cfg_we = 1'b0;
  endtask

  task automatic send(input int ch, input int s, output int l);
    int w;
    w = 0;
    bus.in_valid = 1'b1;
    bus.in_chan = CW'(ch);
    bus.in_sample = DB'(s);
    while (!bus.in_ready && w < 20) begin
      @(posedge clk); #1;
      w++;
    end
    if (w >= 20) chk("ready_wait", w, 0);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.cfg_we = 1'b0;
    l = 0;
    while (!bus.out_valid && l < 20) begin
      @(posedge clk); #1;
      l++;
    end
  endtask

  initial begin
    tbl[0] = '{0, 0, 0, 0, 0, 0, 0};
    tbl[1] = '{0, 1000, 0, 250, 1000, 1000, 0};
    tbl[2] = '{2, 2047, 0, 2047, 2047, 2047, 0};
    tbl[3] = '{2, 2047, 2047, 2047, 0, 2047, 2047};
    tbl[4] = '{2, 2047, BIG_LOW, 0, -2047, 2047, BIG_LOW};
    tbl[5] = '{2, 2047, BIG_LOW, -2047, -2047, 2047, BIG_LOW};
    bus.cfg_we = 1'b0;
    bus.cfg_chan = '0;
    bus.cfg_f = '0;
    bus.cfg_q1 = '0;
    bus.cfg_mode = '0;
    bus.in_valid = 1'b0;
    bus.in_chan = '0;
    bus.in_sample = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", int'(bus.in_ready), 0);
    chk("rst_out_valid", int'(bus.out_valid), 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_rst_in_ready", int'(bus.in_ready), 1);
    chk("post_rst_out_valid", int'(bus.out_valid), 0);
    chk("post_rst_out_chan", int'(bus.out_chan), 0);
    chk_out("post_rst", 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    cfg_write(0, 'h8000, 'h10000, 0);
    cfg_write(2, 'h20000, 0, 0);
    for (int i = 0; i < 6; i++) begin
      send(tbl[i].ch, tbl[i].s, lat);
      chk($sformatf("vec%0d_latency", i), lat, 4);
      chk($sformatf("vec%0d_chan", i), int'(bus.out_chan), tbl[i].ch);
      chk_out($sformatf("vec%0d", i), tbl[i].lo, tbl[i].bd, tbl[i].hi, tbl[i].nt, tbl[i].os);
    end
    for (int i = 0; i < 300; i++) send(0, 1000, lat);
    chk_near("dc_low", int'(bus.out_low), 1000, 2);
    chk_near("dc_band", int'(bus.out_band), 0, 2);
    chk_near("dc_high", int'(bus.out_high), 0, 2);
    @(posedge clk); #1;
    bus.in_valid = 1'b1;
    ic = 0;
    bus.in_chan = '0;
    bus.in_sample = DB'(1000);
    last = -1;
    outs = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      acc = bus.in_ready;
      if (acc) begin
        q.push_back(ic);
        if (last >= 0) chk("iso_gap", c - last, 5);
        last = c;
      end
      if (bus.out_valid) begin
        if (q.size() == 0) chk("iso_spurious_valid", 1, 0);
        else begin
          exp_ch = q.pop_front();
          chk("iso_chan", int'(bus.out_chan), exp_ch);
          if (exp_ch == 1) chk_out("iso_ch1", 0, 0, 0, 0, 0);
          else chk_out("iso_ch0", 1000, 0, 0, 1000, 1000);
          outs++;
        end
      end
      @(posedge clk); #1;
      if (acc) begin
        ic ^= 1;
        bus.in_chan = CW'(ic);
        bus.in_sample = DB'(ic == 1 ? 0 : 1000);
      end
    end
    bus.in_valid = 1'b0;
    chk("iso_outputs", outs, 7);
    repeat (6) @(posedge clk);
    #1;
    bus.cfg_we = 1'b1;
    bus.cfg_chan = '0;
    bus.cfg_f = '0;
    bus.cfg_q1 = 18'h10000;
    bus.cfg_mode = 2'd2;
    send(0, 0, lat);
    chk("race_latency", lat, 4);
    chk_out("race_old", 1000, -250, -1000, 0, 1000);
    send(0, 0, lat);
    chk_out("race_new", 1000, -250, -750, 250, -750);
    bus.in_valid = 1'b1;
    bus.in_chan = CW'(3);
    bus.in_sample = DB'(500);
    chk("bad_ready", int'(bus.in_ready), 1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    chk("bad_stays_idle", int'(bus.in_ready), 1);
    seen = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (bus.out_valid) seen++;
    end
    chk("bad_no_valid", seen, 0);
    send(0, 0, lat);
    chk("after_bad_latency", lat, 4);
    chk_out("after_bad", 1000, -250, -750, 250, -750);
    @(posedge clk); #1;
    bus.in_valid = 1'b1;
    bus.in_chan = '0;
    bus.in_sample = DB'(1000);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_in_ready", int'(bus.in_ready), 0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (bus.out_valid) seen++;
    end
    chk("midrst_no_valid", seen, 0);
    chk_out("midrst", 0, 0, 0, 0, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
